// File: rtl/fifo_synch_level.sv
// ---------------------------------------------------------------------------
// fifo_synch_level
// Single-clock FIFO with arbitrary (non power-of-2) depth, occupancy count,
// programmable almost-full / almost-empty thresholds, synchronous flush,
// overflow / underflow pulses and a standard or first-word-fall-through read.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   flush        synchronous clear of pointers and count (storage untouched)
//   w_en, wdata  write request and data
//   r_en         read request (pop)
//   rdata        read data (registered in standard mode, head word in FWFT)
//   rd_valid     rdata holds a popped word (standard) / a head word (FWFT)
//   full, empty, almost_full, almost_empty   occupancy flags
//   count        current occupancy, 0..DEPTH
//   overflow     one-cycle pulse: a write was rejected
//   underflow    one-cycle pulse: a read was rejected
// ---------------------------------------------------------------------------
module fifo_synch_level #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AF_TH = 6,
    parameter int unsigned AE_TH = 2,
    parameter int unsigned FWFT  = 0,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             w_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             r_en,
    output logic [WIDTH-1:0] rdata,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    w_ptr;
    logic [PW-1:0]    r_ptr;
    logic             rd_ok;
    logic             wr_ok;
    logic [CW-1:0]    count_next;

    // Explicit wrap at DEPTH-1 so non power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A read frees a slot in the same cycle, so a full FIFO can accept rd+wr.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);

    // Next occupancy; rd+wr together leaves count unchanged.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, count and flags; flags are registered from count_next so they
    // always match the count register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) w_ptr <= ptr_inc(w_ptr);
            if (rd_ok) r_ptr <= ptr_inc(r_ptr);
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CW'(DEPTH));
            almost_empty <= (count_next <= CW'(AE_TH));
            almost_full  <= (count_next >= CW'(AF_TH));
            overflow     <= w_en & ~wr_ok;
            underflow    <= r_en & ~rd_ok;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst && !flush) begin
            mem[w_ptr] <= wdata;
        end
    end

    // Read port: head word shown directly (FWFT) or popped into a register.
    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata    = mem[r_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    rdata    <= '0;
                    rd_valid <= 1'b0;
                end else if (rd_ok) begin
                    rdata    <= mem[r_ptr];
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_synch_level.sv
// ---------------------------------------------------------------------------
// tb_fifo_synch_level
// Directed bench for fifo_synch_level. Three instances (DEPTH=5 standard,
// DEPTH=8 standard, DEPTH=3 FWFT) are exercised one at a time; a queue
// model holds the expected contents and supplies every expected output.
// ---------------------------------------------------------------------------
module tb_fifo_synch_level;

    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] flush_v;
    logic [2:0] w_en_v;
    logic [2:0] r_en_v;
    logic [7:0] wdata;

    logic [7:0] rdata0, rdata1, rdata2;
    logic [2:0] rd_valid_v, full_v, empty_v, af_v, ae_v, ov_v, un_v;
    logic [2:0] cnt0;
    logic [3:0] cnt1;
    logic [1:0] cnt2;

    fifo_synch_level #(.WIDTH(8), .DEPTH(5), .AF_TH(4), .AE_TH(1), .FWFT(0)) u_d5 (
        .clk(clk), .rst(rst_v[0]), .flush(flush_v[0]), .w_en(w_en_v[0]), .wdata(wdata),
        .r_en(r_en_v[0]), .rdata(rdata0), .rd_valid(rd_valid_v[0]), .full(full_v[0]),
        .empty(empty_v[0]), .almost_full(af_v[0]), .almost_empty(ae_v[0]), .count(cnt0),
        .overflow(ov_v[0]), .underflow(un_v[0])
    );

    fifo_synch_level #(.WIDTH(8), .DEPTH(8), .AF_TH(6), .AE_TH(2), .FWFT(0)) u_d8 (
        .clk(clk), .rst(rst_v[1]), .flush(flush_v[1]), .w_en(w_en_v[1]), .wdata(wdata),
        .r_en(r_en_v[1]), .rdata(rdata1), .rd_valid(rd_valid_v[1]), .full(full_v[1]),
        .empty(empty_v[1]), .almost_full(af_v[1]), .almost_empty(ae_v[1]), .count(cnt1),
        .overflow(ov_v[1]), .underflow(un_v[1])
    );

    fifo_synch_level #(.WIDTH(8), .DEPTH(3), .AF_TH(2), .AE_TH(0), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst_v[2]), .flush(flush_v[2]), .w_en(w_en_v[2]), .wdata(wdata),
        .r_en(r_en_v[2]), .rdata(rdata2), .rd_valid(rd_valid_v[2]), .full(full_v[2]),
        .empty(empty_v[2]), .almost_full(af_v[2]), .almost_empty(ae_v[2]), .count(cnt2),
        .overflow(ov_v[2]), .underflow(un_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model of the selected instance.
    int         sel;
    int         mdepth, maf, mae, mfwft;
    logic [7:0] mq [$];
    logic [7:0] e_rd;
    logic       e_rv, e_ov, e_un;
    string      phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [7:0] o_rd;
        logic [3:0] o_cnt;
        int         n;
        case (sel)
            0:       begin o_rd = rdata0; o_cnt = {1'b0, cnt0}; end
            1:       begin o_rd = rdata1; o_cnt = cnt1; end
            default: begin o_rd = rdata2; o_cnt = {2'b00, cnt2}; end
        endcase
        n = mq.size();
        chk("count",        32'(o_cnt),          32'(n));
        chk("full",         32'(full_v[sel]),    32'(n == mdepth));
        chk("empty",        32'(empty_v[sel]),   32'(n == 0));
        chk("almost_full",  32'(af_v[sel]),      32'(n >= maf));
        chk("almost_empty", 32'(ae_v[sel]),      32'(n <= mae));
        chk("overflow",     32'(ov_v[sel]),      32'(e_ov));
        chk("underflow",    32'(un_v[sel]),      32'(e_un));
        if (mfwft != 0) begin
            chk("rd_valid", 32'(rd_valid_v[sel]), 32'(n > 0));
            if (n > 0) chk("rdata", 32'(o_rd), 32'(mq[0]));
        end else begin
            chk("rd_valid", 32'(rd_valid_v[sel]), 32'(e_rv));
            chk("rdata",    32'(o_rd),            32'(e_rd));
        end
    endtask

    // One clock of stimulus on the selected instance, then model update and check.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                       input logic fl, input logic rs);
        logic rd_ok, wr_ok;
        rst_v   = '0; flush_v = '0; w_en_v = '0; r_en_v = '0;
        rst_v[sel] = rs; flush_v[sel] = fl; w_en_v[sel] = we; r_en_v[sel] = re;
        wdata = wd;
        @(posedge clk);
        rd_ok = re && (mq.size() > 0);
        wr_ok = we && ((mq.size() < mdepth) || rd_ok);
        if (rs || fl) begin
            mq.delete();
            e_ov = 1'b0; e_un = 1'b0; e_rv = 1'b0; e_rd = 8'h00;
        end else begin
            e_ov = we && !wr_ok;
            e_un = re && !rd_ok;
            if (rd_ok) begin
                e_rd = mq.pop_front();
                e_rv = 1'b1;
            end else begin
                e_rv = 1'b0;
            end
            if (wr_ok) mq.push_back(wd);
        end
        #1;
        check_all();
        rst_v = '0; flush_v = '0; w_en_v = '0; r_en_v = '0;
    endtask

    task automatic select(input int s, input int d, input int af, input int ae, input int fw);
        sel = s; mdepth = d; maf = af; mae = ae; mfwft = fw;
        mq.delete();
        e_rd = 8'h00; e_rv = 1'b0; e_ov = 1'b0; e_un = 1'b0;
    endtask

    initial begin
        rst_v = '1; flush_v = '0; w_en_v = '0; r_en_v = '0; wdata = '0;
        sel = 0;
        repeat (2) @(posedge clk);
        #1 rst_v = '0;

        // DEPTH=5: fill, overflow, drain in order
        select(0, 5, 4, 1, 0);
        phase = "d5_reset";
        cyc(0, 8'h00, 0, 0, 1);
        phase = "d5_fill";
        for (int k = 1; k <= 5; k++) cyc(1, 8'(k * 17), 0, 0, 0);
        phase = "d5_overflow";
        cyc(1, 8'h66, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        phase = "d5_drain";
        for (int k = 0; k < 5; k++) cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);

        // DEPTH=8: underflow, empty rd+wr
        select(1, 8, 6, 2, 0);
        phase = "d8_reset";
        cyc(0, 8'h00, 0, 0, 1);
        phase = "d8_underflow";
        cyc(0, 8'h00, 1, 0, 0);
        cyc(1, 8'hA5, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);

        // Threshold sweep 0..8 then overflow at full
        phase = "d8_thresholds";
        for (int k = 0; k < 8; k++) cyc(1, 8'(k), 0, 0, 0);
        phase = "d8_full_write";
        cyc(1, 8'hEE, 0, 0, 0);

        // Full with simultaneous rd+wr across pointer wrap
        phase = "d8_full_rdwr";
        for (int k = 0; k < 20; k++) cyc(1, 8'(8'h80 + k), 1, 0, 0);
        phase = "d8_drain";
        for (int k = 0; k < 9; k++) cyc(0, 8'h00, 1, 0, 0);

        // Flush with a pending write, then reset mid-burst
        phase = "d8_flush";
        for (int k = 0; k < 4; k++) cyc(1, 8'(8'h40 + k), 0, 0, 0);
        cyc(1, 8'h99, 1, 1, 0);
        cyc(0, 8'h00, 1, 0, 0);
        phase = "d8_rst_burst";
        for (int k = 0; k < 3; k++) cyc(1, 8'(8'h70 + k), 0, 0, 0);
        cyc(1, 8'h77, 1, 0, 1);
        cyc(1, 8'h5A, 0, 0, 0);
        cyc(1, 8'h5B, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);

        // FWFT, DEPTH=3
        select(2, 3, 2, 0, 1);
        phase = "fw_reset";
        cyc(0, 8'h00, 0, 0, 1);
        phase = "fw_fallthrough";
        cyc(1, 8'h3C, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        phase = "fw_fill";
        for (int k = 0; k < 4; k++) cyc(1, 8'(8'hC0 + k), 0, 0, 0);
        phase = "fw_full_rdwr";
        for (int k = 0; k < 5; k++) cyc(1, 8'(8'hD0 + k), 1, 0, 0);
        phase = "fw_drain";
        for (int k = 0; k < 4; k++) cyc(0, 8'h00, 1, 0, 0);
        phase = "fw_flush";
        cyc(1, 8'hE1, 0, 0, 0);
        cyc(1, 8'hE2, 0, 0, 0);
        cyc(1, 8'hE3, 1, 1, 0);
        cyc(1, 8'hE4, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
